acc_seq_ctrl: RTL

Inference sequencer sitting directly downstream of the APB3 control-path slave. It consumes the start/abort/config fields the register interface decodes and drives the accelerator datapath through one inference: image-buffer load, per-patch clause evaluation, class-sum readout with argmax, completion and interrupt. It returns status, result and cycle count to the register interface for PRDATA readback.

---
 rtl/acc_seq_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/acc_seq_ctrl.sv
// Inference sequencer: walks the accelerator datapath through one inference
// (image load, per-patch clause evaluation, class-sum argmax, completion) and
// reports status, result and run length back to the register interface.
module acc_seq_ctrl #(
  parameter int IMG_AW  = 8,
  parameter int PATCH_W = 10,
  parameter int CLASS_W = 4,
  parameter int SUM_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [IMG_AW-1:0]       cfg_img_words,
  input  logic [PATCH_W-1:0]      cfg_num_patches,
  input  logic [CLASS_W-1:0]      cfg_num_classes,
  input  logic                    irq_en,
  input  logic                    irq_clr,
  output logic                    img_rd_en,
  output logic [IMG_AW-1:0]       img_rd_addr,
  output logic                    patch_start,
  output logic [PATCH_W-1:0]      patch_idx,
  input  logic                    patch_done,
  output logic                    cls_rd_en,
  output logic [CLASS_W-1:0]      cls_idx,
  input  logic signed [SUM_W-1:0] cls_sum,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic                    abort_flag,
  output logic                    irq_status,
  output logic                    irq,
  output logic [CLASS_W-1:0]      result_class,
  output logic signed [SUM_W-1:0] result_score,
  output logic [CNT_W-1:0]        cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EVAL, S_WAIT, S_CLASS, S_FLUSH, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Shadow copies of the configuration, frozen for the whole run.
  logic [IMG_AW-1:0]  words_q;
  logic [PATCH_W-1:0] patches_q;
  logic [CLASS_W-1:0] classes_q;

  // Argmax tracking: a strobe issued this cycle is sampled next cycle.
  logic                    smp_valid;
  logic [CLASS_W-1:0]      smp_idx;
  logic [CLASS_W-1:0]      best_class;
  logic signed [SUM_W-1:0] best_score;

  logic cfg_ok;
  logic start_ok;
  logic abort_take;
  logic last_addr;
  logic last_patch;
  logic last_class;

  assign cfg_ok     = (|cfg_img_words) && (|cfg_num_patches) && (|cfg_num_classes);
  assign start_ok   = (state == S_IDLE) && start && cfg_ok;
  assign abort_take = (state != S_IDLE) && abort;
  assign last_addr  = (img_rd_addr == words_q - IMG_AW'(1));
  assign last_patch = (patch_idx == patches_q - PATCH_W'(1));
  assign last_class = (cls_idx == classes_q - CLASS_W'(1));

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update from the same pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a taken abort overrides every transition.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_ok)   state_nxt = S_LOAD;
      S_LOAD:  if (last_addr)  state_nxt = S_EVAL;
      S_EVAL:                  state_nxt = S_WAIT;
      S_WAIT:  if (patch_done) state_nxt = last_patch ? S_CLASS : S_EVAL;
      S_CLASS: if (last_class) state_nxt = S_FLUSH;
      S_FLUSH:                 state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
    if (abort_take) state_nxt = S_IDLE;
  end

  // Strobes and status decoded from the current state.
  always_comb begin
    img_rd_en   = (state == S_LOAD);
    patch_start = (state == S_EVAL);
    cls_rd_en   = (state == S_CLASS);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE) && !abort;
  end

  // Config shadowing and the address/index counters for each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q     <= '0;
      patches_q   <= '0;
      classes_q   <= '0;
      img_rd_addr <= '0;
      patch_idx   <= '0;
      cls_idx     <= '0;
    end else begin
      if (start_ok) begin
        words_q   <= cfg_img_words;
        patches_q <= cfg_num_patches;
        classes_q <= cfg_num_classes;
      end

      if (state_nxt != S_LOAD)  img_rd_addr <= '0;
      else if (state == S_LOAD) img_rd_addr <= img_rd_addr + IMG_AW'(1);

      if (abort_take || state == S_IDLE)  patch_idx <= '0;
      else if (state == S_WAIT && patch_done)
        patch_idx <= last_patch ? '0 : patch_idx + PATCH_W'(1);

      if (state_nxt != S_CLASS)  cls_idx <= '0;
      else if (state == S_CLASS) cls_idx <= cls_idx + CLASS_W'(1);
    end
  end

  // Running argmax; strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_valid  <= 1'b0;
      smp_idx    <= '0;
      best_class <= '0;
      best_score <= '0;
    end else begin
      smp_valid <= cls_rd_en && !abort;
      smp_idx   <= cls_idx;
      if (smp_valid && (smp_idx == '0 || cls_sum > best_score)) begin
        best_score <= cls_sum;
        best_class <= smp_idx;
      end
    end
  end

  // Sticky flags, published results and the interrupt status bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err      <= 1'b0;
      abort_flag   <= 1'b0;
      irq_status   <= 1'b0;
      result_class <= '0;
      result_score <= '0;
    end else begin
      if (state == S_IDLE && start) cfg_err <= !cfg_ok;

      if (start_ok)        abort_flag <= 1'b0;
      else if (abort_take) abort_flag <= 1'b1;

      if (done) begin
        result_class <= best_class;
        result_score <= best_score;
      end

      // Completion beats a coincident clear.
      if (done)         irq_status <= 1'b1;
      else if (irq_clr) irq_status <= 1'b0;
    end
  end

  // Run-length counter: cleared on launch, saturates, frozen while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   cycle_cnt <= '0;
    else if (start_ok)                         cycle_cnt <= '0;
    else if (state != S_IDLE && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  assign irq = irq_status && irq_en;

endmodule
